// File: rtl/btn_debounce_arbiter.sv
// Debounces four direction buttons with one shared settle counter granted round-robin,
// keeps the debounced level vector and queues confirmed presses as 2-bit codes.
module btn_debounce_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 500000,
    parameter int unsigned CNT_W         = 19,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_north,
    input  logic       btn_east,
    input  logic       btn_south,
    input  logic       btn_west,
    output logic [3:0] btn_level,
    output logic       any_pressed,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    input  logic       evt_ready,
    output logic       busy,
    output logic       overflow,
    input  logic       ovf_clr
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, COMMIT = 2'd2} state_t;

    state_t           state, state_nxt;
    logic [3:0]       sync_meta, sync_lvl, pending, level_nxt;
    logic [1:0]       grant, grant_nxt, last_grant, last_grant_nxt, rr_grant;
    logic             rr_found, tgt, tgt_nxt, abort, done, push;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic [1:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [LVL_W-1:0] fill, fill_nxt;
    logic             pop, full, push_ok, drop;
    logic [1:0]       head_nxt;

    // Two-flop synchronizers for the asynchronous raw buttons
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= '0;
            sync_lvl  <= '0;
        end else begin
            sync_meta <= {btn_west, btn_south, btn_east, btn_north};
            sync_lvl  <= sync_meta;
        end
    end

    assign pending = sync_lvl ^ btn_level;
    assign abort   = sync_lvl[grant] != tgt;
    assign done    = cnt == CNT_LAST;

    // First pending button after the last grant; k=4 wraps back to last_grant itself
    always_comb begin
        rr_grant = last_grant;
        rr_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!rr_found && pending[2'(int'(last_grant) + k)]) begin
                rr_grant = 2'(int'(last_grant) + k);
                rr_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rr_found) state_nxt = SETTLE;
            SETTLE:  if (abort) state_nxt = IDLE;
                     else if (done) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant_nxt      = grant;
        tgt_nxt        = tgt;
        cnt_nxt        = cnt;
        last_grant_nxt = last_grant;
        level_nxt      = btn_level;
        push           = 1'b0;
        case (state)
            IDLE: begin
                if (rr_found) begin
                    grant_nxt = rr_grant;
                    tgt_nxt   = sync_lvl[rr_grant];
                    cnt_nxt   = '0;
                end
            end
            SETTLE: begin
                if (abort) begin
                    last_grant_nxt = grant;
                    cnt_nxt        = '0;
                end else if (!done && cnt != '1) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            COMMIT: begin
                level_nxt[grant] = tgt;
                last_grant_nxt   = grant;
                push             = tgt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant       <= '0;
            tgt         <= 1'b0;
            cnt         <= '0;
            last_grant  <= 2'd3;
            btn_level   <= '0;
            any_pressed <= 1'b0;
            busy        <= 1'b0;
        end else begin
            grant       <= grant_nxt;
            tgt         <= tgt_nxt;
            cnt         <= cnt_nxt;
            last_grant  <= last_grant_nxt;
            btn_level   <= level_nxt;
            any_pressed <= |level_nxt;
            busy        <= state_nxt != IDLE;
        end
    end

    // Event FIFO; head is registered so a push into an empty FIFO shows one cycle later
    assign pop      = evt_valid & evt_ready;
    assign full     = fill == LVL_W'(FIFO_DEPTH);
    assign push_ok  = push & (~full | pop);
    assign drop     = push & full & ~pop;
    assign rd_nxt   = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    assign fill_nxt = fill + LVL_W'(push_ok) - LVL_W'(pop);
    assign head_nxt = (push_ok && wr_ptr == rd_nxt) ? grant : mem[rd_nxt];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fill      <= '0;
            evt_valid <= 1'b0;
            evt_code  <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= grant;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            rd_ptr    <= rd_nxt;
            fill      <= fill_nxt;
            evt_valid <= fill_nxt != '0;
            evt_code  <= head_nxt;
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_btn_debounce_arbiter.sv
// Scoreboard bench for btn_debounce_arbiter: expected codes are queued as presses are
// driven and compared when the consumer pops the FIFO.
module tb_btn_debounce_arbiter;
    localparam int unsigned SETTLE = 8;
    localparam int unsigned LAT    = SETTLE + 4;   // raw edge to committed level/event
    localparam int unsigned GAP    = SETTLE + 2;   // IDLE + SETTLE window + COMMIT

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_north, btn_east, btn_south, btn_west;
    logic [3:0] btn_level;
    logic       any_pressed, evt_valid, evt_ready, busy, overflow, ovf_clr;
    logic [1:0] evt_code;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] exp_q[$];
    logic [3:0] cur;

    btn_debounce_arbiter #(
        .SETTLE_CYCLES(SETTLE),
        .CNT_W        (19),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_north  (btn_north),
        .btn_east   (btn_east),
        .btn_south  (btn_south),
        .btn_west   (btn_west),
        .btn_level  (btn_level),
        .any_pressed(any_pressed),
        .evt_valid  (evt_valid),
        .evt_code   (evt_code),
        .evt_ready  (evt_ready),
        .busy       (busy),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btns(input logic [3:0] v);
        {btn_west, btn_south, btn_east, btn_north} = v;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        set_btns(4'h0);
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        exp_q.delete();
        step(3);
        rst_n = 1'b1;
    endtask

    // Consumer side of the scoreboard: every accepted head must match the oldest expected code
    always @(negedge clk) begin
        if (rst_n === 1'b1 && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) check_eq("pop_unexpected", 32'(exp_q.size()), 32'd1);
            else                   check_eq("pop_code", 32'(evt_code), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        do_reset();
        check_eq("rst_level", 32'(btn_level), 32'h0);
        check_eq("rst_valid", 32'(evt_valid), 32'h0);
        check_eq("rst_code",  32'(evt_code),  32'h0);
        check_eq("rst_busy",  32'(busy),      32'h0);
        check_eq("rst_ovf",   32'(overflow),  32'h0);

        // Clean east press: committed exactly LAT edges after the raw change
        set_btns(4'b0010);
        exp_q.push_back(2'd1);
        step(LAT - 1);
        check_eq("t1_level_early", 32'(btn_level), 32'h0);
        check_eq("t1_valid_early", 32'(evt_valid), 32'h0);
        step(1);
        check_eq("t1_level", 32'(btn_level),   32'h2);
        check_eq("t1_any",   32'(any_pressed), 32'h1);
        check_eq("t1_valid", 32'(evt_valid),   32'h1);
        check_eq("t1_code",  32'(evt_code),    32'h1);
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        check_eq("t1_popped", 32'(evt_valid), 32'h0);
        set_btns(4'b0000);
        step(LAT + 1);
        check_eq("t1_release_level", 32'(btn_level),   32'h0);
        check_eq("t1_release_any",   32'(any_pressed), 32'h0);
        check_eq("t1_release_noevt", 32'(evt_valid),   32'h0);

        // Bouncy north press: the abort restarts settling from the final stable edge
        set_btns(4'b0001);
        step(3);
        set_btns(4'b0000);
        step(3);
        check_eq("t2_bounce_noevt", 32'(evt_valid), 32'h0);
        set_btns(4'b0001);
        exp_q.push_back(2'd0);
        step(LAT - 1);
        check_eq("t2_level_early", 32'(btn_level), 32'h0);
        check_eq("t2_valid_early", 32'(evt_valid), 32'h0);
        step(1);
        check_eq("t2_level", 32'(btn_level), 32'h1);
        check_eq("t2_code",  32'(evt_code),  32'h0);
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        set_btns(4'b0000);
        step(LAT + 1);
        check_eq("t2_release_level", 32'(btn_level), 32'h0);
        check_eq("t2_release_noevt", 32'(evt_valid), 32'h0);

        // All four raised together from reset: served N,E,S,W one window apart
        do_reset();
        set_btns(4'hF);
        for (int i = 0; i < 4; i++) exp_q.push_back(2'(i));
        step(LAT);
        check_eq("t3_first_level", 32'(btn_level), 32'h1);
        check_eq("t3_first_code",  32'(evt_code),  32'h0);
        for (int i = 1; i < 4; i++) begin
            step(GAP - 1);
            check_eq("t3_busy",      32'(busy),      32'h1);
            check_eq("t3_level_pre", 32'(btn_level), 32'((1 << i) - 1));
            step(1);
            check_eq("t3_level",     32'(btn_level), 32'((1 << (i + 1)) - 1));
        end
        check_eq("t3_no_ovf", 32'(overflow), 32'h0);
        evt_ready = 1'b1;
        step(4);
        evt_ready = 1'b0;
        check_eq("t3_drained", 32'(evt_valid), 32'h0);
        set_btns(4'h0);
        step(LAT + 3 * GAP + 3);
        check_eq("t3_released", 32'(btn_level), 32'h0);

        // Five presses into a four-entry FIFO with no consumer: the fifth is dropped
        cur = 4'h0;
        for (int i = 0; i < 4; i++) begin
            cur[i] = 1'b1;
            set_btns(cur);
            exp_q.push_back(2'(i));
            step(LAT);
            check_eq("t4_level", 32'(btn_level), 32'(cur));
        end
        cur[0] = 1'b0;
        set_btns(cur);
        step(LAT);
        check_eq("t4_release_ovf", 32'(overflow), 32'h0);
        cur[0] = 1'b1;
        set_btns(cur);
        step(LAT);
        check_eq("t4_level_full", 32'(btn_level), 32'hF);
        check_eq("t4_ovf",        32'(overflow),  32'h1);
        check_eq("t4_head",       32'(evt_code),  32'h0);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        check_eq("t4_ovf_clr", 32'(overflow), 32'h0);
        evt_ready = 1'b1;
        step(4);
        check_eq("t4_drained", 32'(evt_valid), 32'h0);
        step(2);
        check_eq("t4_ready_empty", 32'(evt_valid), 32'h0);
        evt_ready = 1'b0;

        // Full FIFO with a pop in the commit cycle: push and pop both happen
        set_btns(4'h0);
        step(LAT + 3 * GAP + 3);
        cur = 4'h0;
        for (int i = 0; i < 4; i++) begin
            cur[i] = 1'b1;
            set_btns(cur);
            exp_q.push_back(2'(i));
            step(LAT);
        end
        cur[0] = 1'b0;
        set_btns(cur);
        step(LAT);
        cur[0] = 1'b1;
        set_btns(cur);
        exp_q.push_back(2'd0);
        step(LAT - 1);
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        check_eq("t5_no_ovf", 32'(overflow),  32'h0);
        check_eq("t5_valid",  32'(evt_valid), 32'h1);
        check_eq("t5_head",   32'(evt_code),  32'h1);
        step(3);
        check_eq("t5_head_stable", 32'(evt_code), 32'h1);
        evt_ready = 1'b1;
        step(4);
        evt_ready = 1'b0;
        check_eq("t5_drained", 32'(evt_valid), 32'h0);
        check_eq("t5_sb_empty", 32'(exp_q.size()), 32'h0);

        // Reset in the middle of south's settle window, button held through release
        do_reset();
        set_btns(4'b0100);
        step(8);
        check_eq("t6_busy_mid", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_busy",  32'(busy),      32'h0);
        check_eq("t6_rst_level", 32'(btn_level), 32'h0);
        step(2);
        check_eq("t6_rst_valid", 32'(evt_valid), 32'h0);
        check_eq("t6_rst_ovf",   32'(overflow),  32'h0);
        rst_n = 1'b1;
        exp_q.push_back(2'd2);
        step(LAT - 1);
        check_eq("t6_valid_early", 32'(evt_valid), 32'h0);
        step(1);
        check_eq("t6_level", 32'(btn_level), 32'h4);
        check_eq("t6_valid", 32'(evt_valid), 32'h1);
        check_eq("t6_code",  32'(evt_code),  32'h2);
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        check_eq("t6_drained",  32'(evt_valid),    32'h0);
        check_eq("end_sb_empty", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
